// File: rtl/hilo_pkg.sv
// Shared definitions for the Hi/Lo unit: opcodes, FSM encoding and divide-by-zero results.
// Used by hilo_unit_ctrl and, when HILO_DIV_EN is defined, by hilo_divider.
package hilo_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MSUB  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Divide by zero does not trap: quotient saturates to all ones, remainder is the dividend.
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs32(input logic [31:0] value, input logic negate);
        return negate ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/hilo_divider.sv
// Restoring radix-2 divider: 32 iterations on magnitudes, then one cycle where the signs are fixed up.
// Compiled only when HILO_DIV_EN is defined.
`ifdef HILO_DIV_EN
module hilo_divider
    import hilo_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_RUN  = 2'd1,
        DV_FIX  = 2'd2
    } dv_state_e;

    dv_state_e   state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [31:0] dividend_q, dividend_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;

    logic [32:0] rem_shift;
    logic [32:0] trial;

    // quo_q starts as the dividend magnitude and is shifted out MSB-first into the partial remainder.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        dividend_d = dividend_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        rem_shift  = {rem_q, quo_q[31]};
        trial      = rem_shift - {1'b0, div_q};

        case (state_q)
            DV_IDLE: begin
                if (start) begin
                    state_d    = DV_RUN;
                    iter_d     = 5'd31;
                    rem_d      = '0;
                    quo_d      = abs32(A, signed_op & A[31]);
                    div_d      = abs32(B, signed_op & B[31]);
                    dividend_d = A;
                    quo_neg_d  = signed_op & (A[31] ^ B[31]);
                    rem_neg_d  = signed_op & A[31];
                    div_zero_d = (B == 32'd0);
                end
            end
            DV_RUN: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (iter_q == 5'd0) begin
                    state_d = DV_FIX;
                end else begin
                    iter_d = iter_q - 5'd1;
                end
            end
            DV_FIX: begin
                state_d = DV_IDLE;
            end
            default: begin
                state_d = DV_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= DV_IDLE;
            iter_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            dividend_q <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            dividend_q <= dividend_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign done      = (state_q == DV_FIX);
    assign quotient  = div_zero_q ? DIV0_QUOTIENT : abs32(quo_q, quo_neg_q);
    assign remainder = div_zero_q ? dividend_q    : abs32(rem_q, rem_neg_q);

endmodule
`endif

// File: rtl/hilo_unit_ctrl.sv
// Hi/Lo register pair with a multi-cycle multiply/accumulate sequencer that stalls EX while busy.
// Optional DIV/DIVU support is built in when the macro HILO_DIV_EN is defined.
module hilo_unit_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        OpValid,
    input  logic [3:0]  OpCode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        OpReady,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        IllegalOp
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  kind_q, kind_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        illegal_q, illegal_d;

    logic [63:0] acc;
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [63:0] mul_result;

    // Products come from the latched operands, so EX may change A/B once the op is accepted.
    assign acc   = {hi_q, lo_q};
    assign sprod = $signed({{32{opa_q[31]}}, opa_q}) * $signed({{32{opb_q[31]}}, opb_q});
    assign uprod = {32'd0, opa_q} * {32'd0, opb_q};

    always_comb begin
        case (kind_q)
            OP_MULT:  mul_result = sprod;
            OP_MULTU: mul_result = uprod;
            OP_MADD:  mul_result = acc + sprod;
            OP_MSUB:  mul_result = acc - sprod;
            default:  mul_result = sprod;
        endcase
    end

`ifdef HILO_DIV_EN
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign div_start = OpValid && (state_q == ST_IDLE) && ((OpCode == OP_DIV) || (OpCode == OP_DIVU));

    hilo_divider u_divider (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (div_start),
        .signed_op (OpCode == OP_DIV),
        .A         (A),
        .B         (B),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    // Single-edge ops complete in IDLE; anything else parks the FSM until its commit edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (OpValid) begin
                    case (OpCode)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            state_d = ST_MUL;
                            cnt_d   = MUL_LOAD;
                            kind_d  = OpCode;
                            opa_d   = A;
                            opb_d   = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_MFHI: begin
                            rdata_d  = hi_q;
                            rvalid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rdata_d  = lo_q;
                            rvalid_d = 1'b1;
                        end
                        OP_NOP: begin
                        end
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: state_d = ST_DIV;
`endif
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef HILO_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            kind_q    <= OP_NOP;
            opa_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            illegal_q <= illegal_d;
        end
    end

    // Stall is purely combinational so EX sees it in the same cycle it raises OpValid.
    assign OpReady   = (state_q == ST_IDLE);
    assign Stall     = OpValid & ~OpReady;
    assign Busy      = (state_q != ST_IDLE);
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_hilo_unit_ctrl.sv
// Self-checking bench for hilo_unit_ctrl: directed cases then random ops against a Hi/Lo reference model.
// Divide expectations follow whether HILO_DIV_EN is defined for the build.
module tb_hilo_unit_ctrl;

    localparam int unsigned MUL_CYCLES = 4;
    localparam int unsigned DIV_CYCLES = 33;

    typedef enum int {K_SINGLE, K_READ, K_MUL, K_DIV, K_ILLEGAL} kind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = 4'd0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        op_ready, stall, busy, read_valid, illegal_op;
    logic [31:0] hi, lo, read_data;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_rdata = '0;
    int total = 0;
    int bad = 0;

    hilo_unit_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .OpValid   (op_valid),
        .OpCode    (op_code),
        .A         (a_in),
        .B         (b_in),
        .OpReady   (op_ready),
        .Stall     (stall),
        .Busy      (busy),
        .Hi        (hi),
        .Lo        (lo),
        .ReadData  (read_data),
        .ReadValid (read_valid),
        .IllegalOp (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    function automatic kind_e classify(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return K_MUL;
        if (op == 4'd7 || op == 4'd8) return K_READ;
        if (op == 4'd9 || op == 4'd10) begin
`ifdef HILO_DIV_EN
            return K_DIV;
`else
            return K_ILLEGAL;
`endif
        end
        if (op >= 4'd11) return K_ILLEGAL;
        return K_SINGLE;
    endfunction

    // Architectural effect of one op on {Hi,Lo}, written with plain 64-bit arithmetic.
    task automatic modelApply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = a;
        ub  = b;
        sp  = sa * sb;
        acc = {m_hi, m_lo};
        case (classify(op))
            K_MUL: begin
                case (op)
                    4'd1:    acc = sp;
                    4'd2:    acc = ua * ub;
                    4'd3:    acc = acc + sp;
                    default: acc = acc - sp;
                endcase
                m_hi = acc[63:32];
                m_lo = acc[31:0];
            end
            K_READ: m_rdata = (op == 4'd7) ? m_hi : m_lo;
            K_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 4'd9) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
                if (op == 4'd5) m_hi = a;
                if (op == 4'd6) m_lo = a;
            end
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the op fully complete.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        kind_e       k;
        logic [31:0] pre_hi, pre_lo;
        int          cycles;
        k      = classify(op);
        pre_hi = m_hi;
        pre_lo = m_lo;
        op_valid = 1'b1;
        op_code  = op;
        a_in     = a;
        b_in     = b;
        #1;
        checkFlag("ready_at_present", op_ready, 1'b1);
        checkFlag("stall_at_present", stall, 1'b0);
        modelApply(op, a, b);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        checkFlag("read_valid_pulse", read_valid, k == K_READ);
        checkFlag("illegal_pulse", illegal_op, k == K_ILLEGAL);
        if (k == K_READ) checkOutput("read_data", read_data, m_rdata);
        if (k == K_MUL || k == K_DIV) begin
            cycles = (k == K_MUL) ? MUL_CYCLES : DIV_CYCLES;
            for (int i = 0; i < cycles; i++) begin
                checkFlag("busy_in_flight", busy, 1'b1);
                checkOutput("hi_held", hi, pre_hi);
                checkOutput("lo_held", lo, pre_lo);
                @(negedge clk);
            end
            checkFlag("ready_after_commit", op_ready, 1'b1);
        end
        checkFlag("busy_idle", busy, 1'b0);
        checkOutput("hi", hi, m_hi);
        checkOutput("lo", lo, m_lo);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;

        // Reset state, including Stall while OpValid is raised during reset
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 4'd5;
        #1;
        checkFlag("rst_ready", op_ready, 1'b1);
        checkFlag("rst_stall", stall, 1'b0);
        checkFlag("rst_busy", busy, 1'b0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_read_data", read_data, 32'd0);
        checkFlag("rst_read_valid", read_valid, 1'b0);
        checkFlag("rst_illegal", illegal_op, 1'b0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3);
        checkOutput("multu_hi", hi, 32'h0000_0002);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

        applyStimulus(4'd5, 32'd1, 32'd0);
        applyStimulus(4'd6, 32'd0, 32'd0);
        applyStimulus(4'd3, 32'd2, 32'd3);
        checkOutput("madd_hi", hi, 32'd1);
        checkOutput("madd_lo", lo, 32'd6);
        applyStimulus(4'd4, 32'd1, 32'd7);
        checkOutput("msub_hi", hi, 32'd0);
        checkOutput("msub_lo", lo, 32'hFFFF_FFFF);

        // Back-to-back single-edge ops, including a read right after a write
        applyStimulus(4'd5, 32'hCAFE_0001, 32'd0);
        applyStimulus(4'd7, 32'd0, 32'd0);
        applyStimulus(4'd8, 32'd0, 32'd0);
        applyStimulus(4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        applyStimulus(4'd13, 32'hDEAD_BEEF, 32'd1);

        // MFLO presented while a multiply is in flight waits for the commit
        op_valid = 1'b1;
        op_code  = 4'd1;
        a_in     = 32'd5;
        b_in     = 32'd6;
        modelApply(4'd1, 32'd5, 32'd6);
        @(posedge clk);
        @(negedge clk);
        op_code = 4'd8;
        a_in    = 32'h5555_AAAA;
        b_in    = 32'hAAAA_5555;
        #1;
        for (int i = 0; i < MUL_CYCLES; i++) begin
            checkFlag("stall_behind_mul", stall, 1'b1);
            checkFlag("no_early_read", read_valid, 1'b0);
            @(negedge clk);
        end
        checkFlag("stall_released", stall, 1'b0);
        checkFlag("read_not_yet", read_valid, 1'b0);
        checkOutput("stalled_lo", lo, 32'd30);
        modelApply(4'd8, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        checkFlag("stalled_read_valid", read_valid, 1'b1);
        checkOutput("stalled_read_data", read_data, 32'd30);
        @(negedge clk);
        checkFlag("read_valid_one_cycle", read_valid, 1'b0);

        applyStimulus(4'd9, 32'hFFFF_FFF9, 32'd2);
`ifdef HILO_DIV_EN
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
`else
        checkOutput("nodiv_lo", lo, 32'd30);
`endif
        applyStimulus(4'd10, 32'd9, 32'd0);
`ifdef HILO_DIV_EN
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", hi, 32'd9);
`endif

        // Random ops against the model
        for (int n = 0; n < 60; n++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) r_a = 32'($signed(-$urandom_range(1, 100)));
            applyStimulus(r_op, r_a, r_b);
        end

        // Reset two cycles into a multiply discards it
        applyStimulus(4'd5, 32'h0000_1234, 32'd0);
        op_valid = 1'b1;
        op_code  = 4'd1;
        a_in     = 32'h0001_0000;
        b_in     = 32'h0001_0000;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        #1;
        checkFlag("midrst_busy", busy, 1'b0);
        checkFlag("midrst_ready", op_ready, 1'b1);
        checkOutput("midrst_hi", hi, m_hi);
        checkOutput("midrst_lo", lo, m_lo);
        checkOutput("midrst_read_data", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (MUL_CYCLES + 3) @(negedge clk);
        checkFlag("postrst_busy", busy, 1'b0);
        checkOutput("postrst_hi", hi, m_hi);
        checkOutput("postrst_lo", lo, m_lo);
        applyStimulus(4'd3, 32'd7, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
